// File: rtl/dcache_wb_pkg.sv
// Shared definitions for the writeback-stage data cache.
package dcache_wb_pkg;

  // Controller states: idle/lookup, bus transfer in flight, completion cycle.
  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_BUS  = 2'd1,
    DC_DONE = 2'd2
  } dc_state_t;

  // Every transfer is a full 32-bit word.
  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

endpackage : dcache_wb_pkg

// File: rtl/dcache_array.sv
// Direct-mapped storage: valid flops (cleared together on reset), plus tag and
// data arrays with asynchronous read and a single shared write port.
module dcache_array #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  output logic             hit,
  output logic [31:0]      rdata
);

  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // One flop per line; all lines drop to invalid on the same reset edge.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        valid_reg[gi] <= 1'b0;
      end else if (wr_en && (idx == IDX_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  // Tag/data arrays are never cleared; the valid bit guards stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= wr_data;
    end
  end

  assign hit   = valid_reg[idx] && (tag_mem[idx] == tag);
  assign rdata = data_mem[idx];

endmodule : dcache_array

// File: rtl/dcache_wb.sv
// Direct-mapped, write-through, no-write-allocate data cache behind the
// writeback stage. Misses and all stores are sent over a Wishbone B3 classic
// master port while stall_o holds the pipeline.
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  dc_state_t         state_reg, state_next;
  logic              cyc_reg, cyc_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] adr_reg, adr_next;
  logic [31:0]       dat_reg, dat_next;
  logic [31:0]       result_reg, result_next;

  logic              arr_wr;
  logic              arr_wr_en;
  logic [31:0]       arr_wdata;
  logic              stall;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [31:0]       rdata;
  logic [1:0]        unused_byte_bits;

  // Byte offset within the word plays no part in lookup or bus address.
  assign unused_byte_bits = address_i[1:0];

  assign idx = address_i[2+IDX_W-1:2];
  assign tag = address_i[ADDR_W-1:2+IDX_W];

  // Array writes are suppressed while reset is asserted so an in-flight
  // transfer cannot leave a half-written line behind.
  assign arr_wr_en = arr_wr & rst_i;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx     (idx),
    .tag     (tag),
    .wr_en   (arr_wr_en),
    .wr_data (arr_wdata),
    .hit     (hit),
    .rdata   (rdata)
  );

  // State and bus-side registers; reset drops cyc immediately so late acks
  // see no open cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg  <= DC_IDLE;
      cyc_reg    <= 1'b0;
      we_reg     <= 1'b0;
      adr_reg    <= '0;
      dat_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      we_reg     <= we_next;
      adr_reg    <= adr_next;
      dat_reg    <= dat_next;
      result_reg <= result_next;
    end
  end

  // Next-state, bus issue and array update decisions.
  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    we_next     = we_reg;
    adr_next    = adr_reg;
    dat_next    = dat_reg;
    result_next = result_reg;
    arr_wr      = 1'b0;
    arr_wdata   = wb_dat_i;
    stall       = 1'b0;

    case (state_reg)
      DC_IDLE: begin
        if (req_i && (we_i || !hit)) begin
          stall      = 1'b1;
          cyc_next   = 1'b1;
          we_next    = we_i;
          adr_next   = {address_i[ADDR_W-1:2], 2'b00};
          dat_next   = data_i;
          state_next = DC_BUS;
        end
      end
      DC_BUS: begin
        stall = 1'b1;
        if (wb_ack_i) begin
          cyc_next   = 1'b0;
          state_next = DC_DONE;
          if (!we_reg) begin
            result_next = wb_dat_i;
            arr_wr      = 1'b1;
            arr_wdata   = wb_dat_i;
          end else if (hit) begin
            // Write-through on a resident line; misses do not allocate.
            arr_wr    = 1'b1;
            arr_wdata = dat_reg;
          end
        end
      end
      DC_DONE: begin
        state_next = DC_IDLE;
      end
      default: begin
        state_next = DC_IDLE;
        cyc_next   = 1'b0;
      end
    endcase
  end

  assign stall_o  = stall;
  assign data_o   = (state_reg == DC_DONE) ? result_reg : rdata;
  assign wb_cyc_o = cyc_reg;
  assign wb_stb_o = cyc_reg;
  assign wb_we_o  = we_reg;
  assign wb_adr_o = adr_reg;
  assign wb_dat_o = dat_reg;
  assign wb_sel_o = WB_SEL_ALL;

endmodule : dcache_wb

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a Wishbone slave of programmable ack delay.
module tb_dcache_wb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] address_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        stall_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int vectors = 0;
  int miscompares = 0;

  // Slave model: ack in the cycle where slv_cnt reaches slv_lat.
  int          slv_lat = 1;
  int          slv_cnt = 0;
  logic [31:0] slv_rdata = '0;
  logic        ack_force = 1'b0;

  // Per-access observations.
  int          stall_cnt, cyc_cycles;
  logic        cyc_seen, timed_out, adr_stable, stb_bad;
  logic [31:0] rd_data, cap_adr, cap_dat;
  logic        cap_we;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!wb_cyc_o || wb_ack_i) slv_cnt <= 0;
    else slv_cnt <= slv_cnt + 1;
  end

  assign wb_ack_i = (wb_cyc_o && wb_stb_o && (slv_cnt == slv_lat)) || ack_force;
  assign wb_dat_i = slv_rdata;

  dcache_wb #(.LINES(16), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .address_i(address_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  // Drive one access and hold it until stall_o drops; records what was seen.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = w; address_i = a; data_i = d;
    stall_cnt = 0; cyc_cycles = 0; cyc_seen = 0; timed_out = 0;
    adr_stable = 1; stb_bad = 0; cap_adr = '0; cap_dat = '0; cap_we = 0; rd_data = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (wb_stb_o !== wb_cyc_o) stb_bad = 1;
      if (wb_cyc_o) begin
        if (!cyc_seen) begin
          cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_we = wb_we_o;
        end else if (wb_adr_o !== cap_adr) begin
          adr_stable = 0;
        end
        cyc_seen = 1;
        cyc_cycles++;
      end
      if (!stall_o) begin
        rd_data = data_o;
        break;
      end
      stall_cnt++;
      if (i == 199) timed_out = 1;
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    $display("txn we=%0d addr=%08h wdata=%08h stalls=%0d bus_cycles=%0d data_o=%08h",
             w, a, d, stall_cnt, cyc_cycles, rd_data);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++; if (wb_cyc_o !== 1'b0) begin miscompares++; $display("FAIL reset_cyc got=%b exp=0", wb_cyc_o); end
    vectors++; if (wb_stb_o !== 1'b0) begin miscompares++; $display("FAIL reset_stb got=%b exp=0", wb_stb_o); end
    vectors++; if (wb_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b exp=0", wb_we_o); end
    vectors++; if (wb_adr_o !== 32'h0) begin miscompares++; $display("FAIL reset_adr got=%08h exp=00000000", wb_adr_o); end
    vectors++; if (wb_dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_dat got=%08h exp=00000000", wb_dat_o); end
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    vectors++; if (wb_sel_o !== 4'b1111) begin miscompares++; $display("FAIL reset_sel got=%b exp=1111", wb_sel_o); end
    @(posedge clk_i); #1; rst_i = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_read_fill();
    slv_lat = 1; slv_rdata = 32'hDEADBEEF;
    do_access(1'b0, 32'h100, 32'h0);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL fill_timeout got=%b exp=0", timed_out); end
    vectors++; if (stall_cnt != 3) begin miscompares++; $display("FAIL fill_stalls got=%0d exp=3", stall_cnt); end
    vectors++; if (rd_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fill_data got=%08h exp=deadbeef", rd_data); end
    vectors++; if (cap_adr !== 32'h100) begin miscompares++; $display("FAIL fill_adr got=%08h exp=00000100", cap_adr); end
    vectors++; if (cap_we !== 1'b0) begin miscompares++; $display("FAIL fill_we got=%b exp=0", cap_we); end
    slv_rdata = 32'h0;
    do_access(1'b0, 32'h100, 32'h0);
    vectors++; if (stall_cnt != 0) begin miscompares++; $display("FAIL rehit_stalls got=%0d exp=0", stall_cnt); end
    vectors++; if (rd_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rehit_data got=%08h exp=deadbeef", rd_data); end
    vectors++; if (cyc_seen !== 1'b0) begin miscompares++; $display("FAIL rehit_cyc got=%b exp=0", cyc_seen); end
  endtask

  task automatic test_store_hit();
    slv_lat = 1; slv_rdata = 32'h0;
    do_access(1'b1, 32'h100, 32'hCAFEF00D);
    vectors++; if (cap_we !== 1'b1) begin miscompares++; $display("FAIL st_we got=%b exp=1", cap_we); end
    vectors++; if (cap_adr !== 32'h100) begin miscompares++; $display("FAIL st_adr got=%08h exp=00000100", cap_adr); end
    vectors++; if (cap_dat !== 32'hCAFEF00D) begin miscompares++; $display("FAIL st_dat got=%08h exp=cafef00d", cap_dat); end
    vectors++; if (stall_cnt != 3) begin miscompares++; $display("FAIL st_stalls got=%0d exp=3", stall_cnt); end
    do_access(1'b0, 32'h100, 32'h0);
    vectors++; if (stall_cnt != 0) begin miscompares++; $display("FAIL st_rd_stalls got=%0d exp=0", stall_cnt); end
    vectors++; if (rd_data !== 32'hCAFEF00D) begin miscompares++; $display("FAIL st_rd_data got=%08h exp=cafef00d", rd_data); end
  endtask

  task automatic test_conflict();
    slv_lat = 1; slv_rdata = 32'h11111140;
    do_access(1'b0, 32'h140, 32'h0);
    vectors++; if (stall_cnt != 3) begin miscompares++; $display("FAIL conf1_stalls got=%0d exp=3", stall_cnt); end
    vectors++; if (rd_data !== 32'h11111140) begin miscompares++; $display("FAIL conf1_data got=%08h exp=11111140", rd_data); end
    slv_rdata = 32'h0BADF00D;
    do_access(1'b0, 32'h100, 32'h0);
    vectors++; if (cyc_seen !== 1'b1) begin miscompares++; $display("FAIL conf2_cyc got=%b exp=1", cyc_seen); end
    vectors++; if (rd_data !== 32'h0BADF00D) begin miscompares++; $display("FAIL conf2_data got=%08h exp=0badf00d", rd_data); end
    // Store to the same index with another tag must not disturb the resident line.
    do_access(1'b1, 32'h140, 32'h77777777);
    vectors++; if (cap_we !== 1'b1) begin miscompares++; $display("FAIL conf_st_we got=%b exp=1", cap_we); end
    slv_rdata = 32'h0;
    do_access(1'b0, 32'h100, 32'h0);
    vectors++; if (stall_cnt != 0) begin miscompares++; $display("FAIL conf_keep_stalls got=%0d exp=0", stall_cnt); end
    vectors++; if (rd_data !== 32'h0BADF00D) begin miscompares++; $display("FAIL conf_keep_data got=%08h exp=0badf00d", rd_data); end
  endtask

  task automatic test_store_miss();
    slv_lat = 1; slv_rdata = 32'h0;
    do_access(1'b1, 32'h204, 32'h5A5A5A5A);
    vectors++; if (cyc_seen !== 1'b1) begin miscompares++; $display("FAIL stm_cyc got=%b exp=1", cyc_seen); end
    vectors++; if (cap_adr !== 32'h204) begin miscompares++; $display("FAIL stm_adr got=%08h exp=00000204", cap_adr); end
    vectors++; if (cap_dat !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL stm_dat got=%08h exp=5a5a5a5a", cap_dat); end
    slv_rdata = 32'h00C0FFEE;
    do_access(1'b0, 32'h204, 32'h0);
    vectors++; if (stall_cnt != 3) begin miscompares++; $display("FAIL stm_ld_stalls got=%0d exp=3", stall_cnt); end
    vectors++; if (rd_data !== 32'h00C0FFEE) begin miscompares++; $display("FAIL stm_ld_data got=%08h exp=00c0ffee", rd_data); end
  endtask

  task automatic test_slow_ack();
    slv_lat = 4; slv_rdata = 32'h0;
    do_access(1'b1, 32'h103, 32'h12345678);
    vectors++; if (cyc_cycles != 5) begin miscompares++; $display("FAIL slow_cyc_cycles got=%0d exp=5", cyc_cycles); end
    vectors++; if (stall_cnt != 6) begin miscompares++; $display("FAIL slow_stalls got=%0d exp=6", stall_cnt); end
    vectors++; if (cap_adr !== 32'h100) begin miscompares++; $display("FAIL slow_adr got=%08h exp=00000100", cap_adr); end
    vectors++; if (adr_stable !== 1'b1) begin miscompares++; $display("FAIL slow_adr_stable got=%b exp=1", adr_stable); end
    vectors++; if (stb_bad !== 1'b0) begin miscompares++; $display("FAIL slow_stb_eq_cyc got=%b exp=0", stb_bad); end
    slv_lat = 1;
    do_access(1'b0, 32'h100, 32'h0);
    vectors++; if (stall_cnt != 0) begin miscompares++; $display("FAIL slow_rd_stalls got=%0d exp=0", stall_cnt); end
    vectors++; if (rd_data !== 32'h12345678) begin miscompares++; $display("FAIL slow_rd_data got=%08h exp=12345678", rd_data); end
  endtask

  task automatic test_stray_ack();
    @(posedge clk_i); #1; ack_force = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1; ack_force = 1'b0;
    @(negedge clk_i);
    vectors++; if (wb_cyc_o !== 1'b0) begin miscompares++; $display("FAIL stray_cyc got=%b exp=0", wb_cyc_o); end
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL stray_stall got=%b exp=0", stall_o); end
    $display("txn stray ack with no request");
  endtask

  task automatic test_reset_mid_bus();
    slv_lat = 10; slv_rdata = 32'h0;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; address_i = 32'h300;
    @(negedge clk_i);
    @(negedge clk_i);
    vectors++; if (wb_cyc_o !== 1'b1) begin miscompares++; $display("FAIL rmb_in_bus got=%b exp=1", wb_cyc_o); end
    @(posedge clk_i); #1; rst_i = 1'b0; req_i = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(negedge clk_i);
    vectors++; if (wb_cyc_o !== 1'b0) begin miscompares++; $display("FAIL rmb_cyc got=%b exp=0", wb_cyc_o); end
    vectors++; if (wb_stb_o !== 1'b0) begin miscompares++; $display("FAIL rmb_stb got=%b exp=0", wb_stb_o); end
    vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rmb_stall got=%b exp=0", stall_o); end
    $display("txn reset during bus cycle");
    slv_lat = 1; slv_rdata = 32'hA5A50100;
    do_access(1'b0, 32'h100, 32'h0);
    vectors++; if (stall_cnt != 3) begin miscompares++; $display("FAIL rmb_miss_stalls got=%0d exp=3", stall_cnt); end
    vectors++; if (rd_data !== 32'hA5A50100) begin miscompares++; $display("FAIL rmb_miss_data got=%08h exp=a5a50100", rd_data); end
  endtask

  initial begin
    test_reset();
    test_read_fill();
    test_store_hit();
    test_conflict();
    test_store_miss();
    test_slow_ack();
    test_stray_ack();
    test_reset_mid_bus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dcache_wb
